bit_serial_alu_ctrl: RTL and testbench

Sequences a single 1-bit full-adder cell over WIDTH cycles to perform multi-bit add or subtract, LSB first. It is the area-minimal arithmetic option for the CPU datapath: the core issues an operation with a start/done handshake and reads back the result and flags. Operand latching, B inversion for subtract, carry chaining and flag generation all live here. The adder cell itself is purely combinational.

---
 rtl/bit_serial_alu_ctrl.sv | 120 ++++++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell is stepped over WIDTH
// cycles, LSB first, with start/done handshake and registered result flags.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_carry;
  logic             r_cmsb;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             w_sum;
  logic             w_cell_cout;
  logic             w_load;

  // The single combinational full-adder cell.
  assign w_sum       = r_sa[0] ^ r_sb[0] ^ r_carry;
  assign w_cell_cout = (r_sa[0] & r_sb[0]) | (r_carry & (r_sa[0] ^ r_sb[0]));
  assign w_load      = (r_state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start) w_next_state = RUN;
      RUN: begin
        if (abort)              w_next_state = IDLE;
        else if (r_cnt == LAST) w_next_state = FIN;
      end
      FIN:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Subtract is A + ~B + 1: the +1 enters through the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_sa    <= a;
      r_sb    <= op_sub ? ~b : b;
      r_carry <= op_sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sr    <= {w_sum, r_sr[WIDTH-1:1]};
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_carry <= w_cell_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (r_cnt == PENULT) r_cmsb <= w_cell_cout;
    end
  end

  // The carry out of bit WIDTH-2 is the carry into the MSB, kept for overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_busy <= (w_next_state == RUN);
      r_done <= (r_state == FIN);
      if (r_state == FIN) begin
        r_result <= r_sr;
        r_cout   <= r_carry;
        r_ovf    <= r_cmsb ^ r_carry;
        r_zero   <= (r_sr == '0);
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign carryout = r_cout;
  assign overflow = r_ovf;
  assign zero     = r_zero;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench for bit_serial_alu_ctrl: WIDTH=8 instance against an
// arithmetic reference model, plus a WIDTH=32 smoke instance.
module tb_bit_serial_alu_ctrl;

  localparam int W   = 8;
  localparam int W32 = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carryout, overflow, zero;
  logic [W-1:0] result;

  logic           start32 = 1'b0;
  logic           opSub32 = 1'b0;
  logic           abort32 = 1'b0;
  logic [W32-1:0] a32 = '0;
  logic [W32-1:0] b32 = '0;
  logic           busy32, done32, carry32, ovf32, zero32;
  logic [W32-1:0] result32;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bit_serial_alu_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .abort(abort),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  bit_serial_alu_ctrl #(.WIDTH(W32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op_sub(opSub32), .abort(abort32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .result(result32),
    .carryout(carry32), .overflow(ovf32), .zero(zero32)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {carry out, result} of A+B or A-B, and signed overflow.
  function automatic logic [W:0] refSum(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    logic [W:0] yy;
    yy = sub ? {1'b0, ~y} : {1'b0, y};
    return {1'b0, x} + yy + {{W{1'b0}}, sub};
  endfunction

  function automatic logic refOvf(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    logic [W-1:0] r;
    r = sub ? (x - y) : (x + y);
    if (sub) return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else     return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Behavioural model: mAge counts edges since the accepting edge; -1 when idle.
  int           mAge = -1;
  int           opsEnded = 0;
  logic [W-1:0] pRes = '0;
  logic         pCout = 1'b0;
  logic         pOvf = 1'b0;
  logic         expBusy = 1'b0;
  logic         expDone = 1'b0;
  logic [W-1:0] expResult = '0;
  logic         expCout = 1'b0;
  logic         expOvf = 1'b0;
  logic         expZero = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mAge      <= -1;
      expBusy   <= 1'b0;
      expDone   <= 1'b0;
      expResult <= '0;
      expCout   <= 1'b0;
      expOvf    <= 1'b0;
      expZero   <= 1'b1;
    end else begin
      expDone <= 1'b0;
      if (mAge < 0) begin
        if (start) begin
          pRes    <= refSum(a, b, op_sub)[W-1:0];
          pCout   <= refSum(a, b, op_sub)[W];
          pOvf    <= refOvf(a, b, op_sub);
          mAge    <= 0;
          expBusy <= 1'b1;
        end
      end else if (mAge < W) begin
        if (abort) begin
          mAge     <= -1;
          expBusy  <= 1'b0;
          opsEnded <= opsEnded + 1;
        end else begin
          mAge    <= mAge + 1;
          expBusy <= (mAge + 1 < W);
        end
      end else begin
        expResult <= pRes;
        expCout   <= pCout;
        expOvf    <= pOvf;
        expZero   <= (pRes == '0);
        expDone   <= 1'b1;
        mAge      <= -1;
        expBusy   <= 1'b0;
        opsEnded  <= opsEnded + 1;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("busy", busy, expBusy);
    checkOutput("done", done, expDone);
    checkOutput("result", result, expResult);
    checkOutput("carryout", carryout, expCout);
    checkOutput("overflow", overflow, expOvf);
    checkOutput("zero", zero, expZero);
  end

  task automatic applyStimulus(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic sub);
    @(negedge clk);
    a = ai; b = bi; op_sub = sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int edges);
    edges = 0;
    while (edges < 100) begin
      @(negedge clk);
      edges++;
      if (done) break;
    end
  endtask

  task automatic checkFlags(input string tag, input logic [W-1:0] r, input logic c, input logic v, input logic z);
    checkOutput({tag, "_result"}, result, r);
    checkOutput({tag, "_carry"}, carryout, c);
    checkOutput({tag, "_ovf"}, overflow, v);
    checkOutput({tag, "_zero"}, zero, z);
    checkOutput({tag, "_model_result"}, expResult, r);
  endtask

  initial begin
    int  edges;
    int  cyc;
    bit  sawDone;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    sawDone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) sawDone = 1;
    end
    checkOutput("idle_no_done", sawDone, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_zero", zero, 1);
    checkOutput("rst_zero32", zero32, 1);

    // WIDTH=32 smoke: 0xFFFFFFFF + 1 wraps to zero with carry.
    @(negedge clk);
    a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; opSub32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    edges = 0;
    while (edges < 100) begin
      @(negedge clk);
      edges++;
      if (done32) break;
    end
    checkOutput("w32_latency", edges, W32 + 1);
    checkOutput("w32_result", result32, 0);
    checkOutput("w32_carry", carry32, 1);
    checkOutput("w32_zero", zero32, 1);

    applyStimulus(8'h7F, 8'h01, 1'b0);
    waitDone(edges);
    checkOutput("add_latency", edges, W + 1);
    checkFlags("add7f", 8'h80, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);

    applyStimulus(8'h05, 8'h05, 1'b1);
    waitDone(edges);
    checkFlags("sub_eq", 8'h00, 1'b1, 1'b0, 1'b1);

    applyStimulus(8'h03, 8'h05, 1'b1);
    waitDone(edges);
    checkFlags("sub_neg", 8'hFE, 1'b0, 1'b0, 1'b0);

    // Extra start pulses while busy must not disturb the operands.
    applyStimulus(8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    a = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(edges);
    checkFlags("ignore_start", 8'h00, 1'b1, 1'b0, 1'b1);

    applyStimulus(8'h7F, 8'h01, 1'b0);
    waitDone(edges);
    checkFlags("pre_abort", 8'h80, 1'b0, 1'b1, 1'b0);

    applyStimulus(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_idle", busy, 0);
    sawDone = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) sawDone = 1;
    end
    checkOutput("abort_no_done", sawDone, 0);
    checkFlags("abort_hold", 8'h80, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of an operation.
    applyStimulus(8'h55, 8'h0F, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_busy", busy, 0);
    checkOutput("async_done", done, 0);
    checkOutput("async_result", result, 0);
    checkOutput("async_carry", carryout, 0);
    checkOutput("async_ovf", overflow, 0);
    checkOutput("async_zero", zero, 1);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    cyc = 0;
    opsEnded = 0;
    while (opsEnded < 1000 && cyc < 40000) begin
      @(negedge clk);
      start  = ($urandom_range(0, 2) == 0);
      a      = W'($urandom);
      b      = W'($urandom);
      op_sub = 1'($urandom_range(0, 1));
      abort  = ($urandom_range(0, 29) == 0);
      cyc++;
    end
    checkOutput("random_ops_complete", (opsEnded >= 1000), 1);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
